// File: rtl/cj_cosim_checker.sv
// Lockstep co-simulation checker: compares DUT retirements against a queued golden
// reference stream and owns the sticky 64-bit tohost completion word.
module cj_cosim_checker #(
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        commit_valid,
    input  logic [63:0] commit_pc,
    input  logic [31:0] commit_insn,
    input  logic        commit_wen,
    input  logic [4:0]  commit_rd,
    input  logic [63:0] commit_wdata,
    input  logic        ref_valid,
    input  logic [63:0] ref_pc,
    input  logic [31:0] ref_insn,
    input  logic        ref_wen,
    input  logic [4:0]  ref_rd,
    input  logic [63:0] ref_wdata,
    input  logic        host_wr_valid,
    input  logic [63:0] host_wr_data,
    output logic [63:0] tohost
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] insn;
        logic        wen;
        logic [4:0]  rd;
        logic [63:0] wdata;
    } entry_t;

    entry_t      mem [FIFO_DEPTH];
    entry_t      cmt, refe, head;
    logic [AW:0] wptr, rptr;
    logic        empty, full, bypass, underflow, overflow, mismatch, push, pop;

    assign cmt  = {commit_pc, commit_insn, commit_wen, commit_rd, commit_wdata};
    assign refe = {ref_pc, ref_insn, ref_wen, ref_rd, ref_wdata};

    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);

    // An empty FIFO with a same-cycle push hands the entry straight to the comparator.
    assign bypass    = empty && ref_valid && commit_valid;
    assign underflow = commit_valid && empty && !ref_valid;
    assign overflow  = ref_valid && full && !commit_valid;
    assign push      = ref_valid && !overflow && !bypass;
    assign pop       = commit_valid && !empty;

    always_comb begin
        head     = bypass ? refe : mem[rptr[AW-1:0]];
        mismatch = 1'b0;
        if (commit_valid && !underflow) begin
            if (cmt.pc != head.pc || cmt.insn != head.insn || cmt.wen != head.wen)
                mismatch = 1'b1;
            else if (cmt.wen && cmt.rd != head.rd)
                mismatch = 1'b1;
            else if (cmt.wen && cmt.rd != 5'd0 && cmt.wdata != head.wdata)
                mismatch = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
        end
    end

    // Storage needs no reset; validity is tracked entirely by the pointers.
    always_ff @(posedge clock) begin
        if (push) mem[wptr[AW-1:0]] <= refe;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tohost <= '0;
        end else if (!tohost[0]) begin
            if (underflow)
                tohost <= 64'd9;
            else if (mismatch)
                tohost <= 64'd7;
            else if (overflow)
                tohost <= 64'd13;
            else if (host_wr_valid && host_wr_data[0])
                tohost <= host_wr_data;
        end
    end
endmodule

// File: tb/tb_cj_cosim_checker.sv
// Directed bench for cj_cosim_checker: a queue-based reference model checked every
// negedge, plus hand-computed literal checkpoints.
module tb_cj_cosim_checker;
    localparam int DEPTH = 8;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        commit_valid = 0, commit_wen = 0, ref_valid = 0, ref_wen = 0, host_wr_valid = 0;
    logic [63:0] commit_pc = 0, commit_wdata = 0, ref_pc = 0, ref_wdata = 0, host_wr_data = 0;
    logic [31:0] commit_insn = 0, ref_insn = 0;
    logic [4:0]  commit_rd = 0, ref_rd = 0;
    logic [63:0] tohost;

    cj_cosim_checker #(.FIFO_DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset),
        .commit_valid(commit_valid), .commit_pc(commit_pc), .commit_insn(commit_insn),
        .commit_wen(commit_wen), .commit_rd(commit_rd), .commit_wdata(commit_wdata),
        .ref_valid(ref_valid), .ref_pc(ref_pc), .ref_insn(ref_insn),
        .ref_wen(ref_wen), .ref_rd(ref_rd), .ref_wdata(ref_wdata),
        .host_wr_valid(host_wr_valid), .host_wr_data(host_wr_data),
        .tohost(tohost)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] insn;
        logic        wen;
        logic [4:0]  rd;
        logic [63:0] wdata;
    } ent_t;

    int          vectors = 0;
    int          miscompares = 0;
    logic [63:0] exp_tohost = 0;
    ent_t        q[$];

    function automatic bit differs(ent_t c, ent_t r);
        if (c.pc != r.pc || c.insn != r.insn || c.wen != r.wen) return 1;
        if (c.wen && c.rd != r.rd) return 1;
        if (c.wen && c.rd != 0 && c.wdata != r.wdata) return 1;
        return 0;
    endfunction

    // Reference model: a plain queue of outstanding reference entries.
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            exp_tohost <= 64'd0;
            q.delete();
        end else begin
            automatic ent_t c = '{commit_pc, commit_insn, commit_wen, commit_rd, commit_wdata};
            automatic ent_t r = '{ref_pc, ref_insn, ref_wen, ref_rd, ref_wdata};
            automatic bit   uf = 0, mm = 0, of = 0, consumed = 0;
            if (commit_valid) begin
                if (q.size() == 0) begin
                    if (ref_valid) begin mm = differs(c, r); consumed = 1; end
                    else uf = 1;
                end else begin
                    mm = differs(c, q.pop_front());
                end
            end
            if (ref_valid && !consumed) begin
                if (q.size() >= DEPTH) of = 1;
                else q.push_back(r);
            end
            if (!exp_tohost[0]) begin
                if (uf) exp_tohost <= 64'd9;
                else if (mm) exp_tohost <= 64'd7;
                else if (of) exp_tohost <= 64'd13;
                else if (host_wr_valid && host_wr_data[0]) exp_tohost <= host_wr_data;
            end
        end
    end

    always @(negedge clock) begin
        vectors++;
        if (tohost !== exp_tohost) begin
            miscompares++;
            $display("FAIL model_cmp @%0t: tohost=%h want %h", $time, tohost, exp_tohost);
        end
    end

    task automatic lit(input string name, input logic [63:0] want);
        vectors++;
        if (tohost !== want) begin
            miscompares++;
            $display("FAIL %s: tohost=%h want %h", name, tohost, want);
        end
    endtask

    function automatic ent_t mk(input int i);
        ent_t e;
        e.pc    = 64'h8000_0000 + 64'(4 * i);
        e.insn  = 32'h0000_0013 | (32'(i) << 7);
        e.wen   = 1'b1;
        e.rd    = 5'((i % 31) + 1);
        e.wdata = 64'h1111 * 64'(i + 1);
        return e;
    endfunction

    task automatic set_ref(input ent_t e);
        ref_valid = 1; ref_pc = e.pc; ref_insn = e.insn;
        ref_wen = e.wen; ref_rd = e.rd; ref_wdata = e.wdata;
    endtask

    task automatic set_cmt(input ent_t e);
        commit_valid = 1; commit_pc = e.pc; commit_insn = e.insn;
        commit_wen = e.wen; commit_rd = e.rd; commit_wdata = e.wdata;
    endtask

    task automatic host(input logic [63:0] d);
        host_wr_valid = 1; host_wr_data = d;
    endtask

    // Advance one edge, then return all valids to idle and settle past the negedge.
    task automatic step();
        @(negedge clock);
        commit_valid = 0; ref_valid = 0; host_wr_valid = 0;
        #1;
    endtask

    task automatic do_reset(input string name);
        #2 reset = 1;
        #1 lit(name, 64'd0);
        @(negedge clock);
        #1 reset = 0;
    endtask

    initial begin
        ent_t e;
        #1 lit("reset_state", 64'd0);
        @(negedge clock);
        #1 reset = 0;

        // Clean run: 3 pushes, 3 matching commits, an even host store (ignored), then 1.
        for (int i = 0; i < 3; i++) begin set_ref(mk(i)); step(); end
        for (int i = 0; i < 3; i++) begin set_cmt(mk(i)); step(); end
        lit("clean_commits", 64'd0);
        host(64'd6); step();
        lit("even_store_ignored", 64'd0);
        host(64'd1); step();
        lit("pass", 64'd1);
        set_cmt(mk(9)); step();
        lit("sticky_pass", 64'd1);
        do_reset("reset_after_pass");

        // PC mismatch, then later pass store must not override.
        e = mk(0); set_ref(e); step();
        e.pc = 64'h8000_0004; set_cmt(e); step();
        lit("pc_mismatch", 64'd7);
        host(64'd1); step();
        lit("sticky_mismatch", 64'd7);
        do_reset("midrun_reset_from_7");

        // Underflow.
        set_cmt(mk(1)); step();
        lit("underflow", 64'd9);
        do_reset("reset_after_uf");

        // Bypass on empty, then overflow with a host store competing.
        set_ref(mk(2)); set_cmt(mk(2)); step();
        lit("bypass_ok", 64'd0);
        for (int i = 0; i < DEPTH; i++) begin set_ref(mk(i)); step(); end
        lit("fill_full", 64'd0);
        set_ref(mk(20)); host(64'd3); step();
        lit("overflow_over_host", 64'd13);
        do_reset("reset_after_of");

        // 9th push alongside a pop is legal; drain exactly, then one more commit underflows.
        for (int i = 0; i < DEPTH; i++) begin set_ref(mk(i)); step(); end
        set_ref(mk(8)); set_cmt(mk(0)); step();
        lit("push_pop_full", 64'd0);
        for (int i = 1; i <= DEPTH; i++) begin set_cmt(mk(i)); step(); end
        lit("drain_ok", 64'd0);
        set_cmt(mk(0)); step();
        lit("drain_then_uf", 64'd9);
        do_reset("reset_after_drain");

        // rd=0 write data ignored; wen=0 ignores rd; rd=5 data compared, host store loses.
        e = mk(3); e.rd = 0; set_ref(e); step();
        e.wdata = 64'hDEAD; set_cmt(e); step();
        lit("rd0_wdata_ignored", 64'd0);
        e = mk(4); e.wen = 0; set_ref(e); step();
        e.rd = 5'd17; e.wdata = 64'hBEEF; set_cmt(e); step();
        lit("wen0_rd_ignored", 64'd0);
        e = mk(5); e.rd = 5; set_ref(e); step();
        e.wdata = 64'hDEAD; set_cmt(e); host(64'd1); step();
        lit("rd5_wdata_mismatch", 64'd7);
        do_reset("reset_after_rd5");

        // Reset with a non-empty FIFO empties it: next bare commit underflows.
        set_ref(mk(0)); step();
        set_ref(mk(1)); step();
        do_reset("reset_nonempty");
        set_cmt(mk(0)); host(64'd1); step();
        lit("uf_over_host", 64'd9);
        do_reset("reset_before_clean");

        // Clean sequence after reset; odd failure code stored verbatim.
        for (int i = 0; i < 2; i++) begin set_ref(mk(i + 10)); step(); end
        for (int i = 0; i < 2; i++) begin set_cmt(mk(i + 10)); step(); end
        host(64'h2B); step();
        lit("host_verbatim", 64'h2B);
        do_reset("reset_final");
        set_ref(mk(30)); set_cmt(mk(30)); step();
        host(64'd1); step();
        lit("final_pass", 64'd1);

        repeat (2) @(negedge clock);
        #1 $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, want completion");
        $fatal(1);
    end
endmodule

// File: doc/cj_cosim_checker.md
# cj_cosim_checker

Lockstep co-simulation checker that sits beside the core in the simulation top. It compares every retired instruction of the DUT core against a golden-model reference stream, queued in an internal FIFO, and owns the 64-bit `tohost` completion word that the testbench polls. `tohost` bit 0 set means the run has ended. Bits 63:1 carry the exit code: 0 = pass, non-zero = failure class.

## Interface
- `FIFO_DEPTH`, default 8: reference-queue entries; power of two, ≥2.
- `clock` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-high; clears all state.
- `commit_valid` input 1: DUT retired one instruction this cycle.
- `commit_pc` input 64: PC of the retired instruction.
- `commit_insn` input 32: instruction word.
- `commit_wen` input 1: instruction wrote an integer register.
- `commit_rd` input 5: destination register.
- `commit_wdata` input 64: value written.
- `ref_valid` input 1: golden model pushes one reference entry.
- `ref_pc`, `ref_insn`, `ref_wen`, `ref_rd`, `ref_wdata` inputs 64/32/1/5/64: fields of the reference entry.
- `host_wr_valid` input 1: the core stores to the tohost MMIO address.
- `host_wr_data` input 64: store data.
- `tohost` output 64: completion word, registered.
- Harness ties unused inputs to 0; with all inputs 0, `tohost` stays 0 forever.

## Operation
- Reference FIFO of `FIFO_DEPTH` entries, each holding {pc, insn, wen, rd, wdata} (166 bits).
  - Push on `ref_valid`; pop on `commit_valid`.
  - Push and pop in the same cycle is legal at any occupancy, including empty.
  - On empty with simultaneous push: the pushed entry is bypassed to the comparator, and the FIFO stays empty.
- Compare on `commit_valid` against the head entry (or the bypassed entry). Mismatch if any of these differ:
  - pc, insn, or wen;
  - when wen=1: rd;
  - when wen=1 and rd≠0: wdata.
  - rd=0 write data is never compared.
- Exit codes; `tohost` is loaded with `{code, 1'b1}`:
  - host store with data bit 0 = 1: `tohost` ← `host_wr_data` verbatim (value 1 = pass).
  - host store with data bit 0 = 0: ignored.
  - commit mismatch: code 3 → `tohost` = 7.
  - commit with FIFO empty and no same-cycle push (underflow): code 4 → 9.
  - `ref_valid` while FIFO full and no same-cycle pop (overflow): code 6 → 13. The pushed entry is dropped.
  - Code 2 (value 5) is reserved for the testbench timeout and is never produced here.
- Same-cycle priority: underflow > mismatch > overflow > host store.
- Sticky: once `tohost` bit 0 = 1, `tohost` holds its value until reset. Later events are ignored, but FIFO push/pop continues.
- After a failure, comparisons still pop the FIFO; no new code is recorded.

## Timing
- Reset (asynchronous assert, any time): `tohost` = 0, FIFO empty, read and write pointers = 0. Effective immediately, even mid-run.
- Event at rising edge N → `tohost` updated at edge N, visible from N for the rest of the cycle. The testbench samples on the negedge of the same cycle.
- One commit and one reference push per cycle maximum.
- Pointers are `log2(FIFO_DEPTH)+1` bits wide and wrap modulo 2·`FIFO_DEPTH`.
  - full = MSBs differ and low bits equal.
  - empty = pointers equal.
- No combinational path from any input to `tohost`.

## Test plan
- Push 3 reference entries, then 3 matching commits, then host store of 1 → `tohost` = 1 one edge after the store; FIFO empty.
- Push pc=0x80000000; commit pc=0x80000004 → `tohost` = 7 after that edge. A later host store of 1 leaves it at 7.
- Commit with FIFO empty and no push → `tohost` = 9. Commit and push in the same cycle with matching fields on an empty FIFO → no error.
- With `FIFO_DEPTH`=8: 8 pushes, then a 9th push without a pop → `tohost` = 13. A 9th push in a pop cycle → no error.
- Commit wen=1, rd=0, wdata differing from the reference → no error. The same case with rd=5 → `tohost` = 7.
- Assert reset mid-run while `tohost` = 7 → `tohost` = 0 and FIFO empty immediately. A clean sequence afterwards reaches `tohost` = 1.
